// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front-end control stage:
// start/stop FSM encoding, button indices and default timing constants.
package stopwatch_pkg;

    // Start/stop button classification states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,    // no start/stop press in progress
        HELD = 2'd1,    // press accepted, still deciding short vs long
        LONG = 2'd2     // long press already acted on, waiting for release
    } ss_state_t;

    // Index of each button in the debouncer bank.
    localparam int BTN_SS  = 0;
    localparam int BTN_LAP = 1;
    localparam int NUM_BTN = 2;

    // Board timing defaults: 10 ms debounce and 1 s long press at 27 MHz.
    localparam int CLK_HZ          = 27_000_000;
    localparam int DEBOUNCE_CYCLES = CLK_HZ / 100;
    localparam int LONG_CYCLES     = CLK_HZ;

    // Smallest counter width able to hold the value n.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((n >> w) != 0) begin
            w++;
        end
        return w;
    endfunction

endpackage : stopwatch_pkg

// File: rtl/btn_debounce.sv
// One raw active-low button: 2-FF synchroniser, stable-level debouncer
// and one-cycle press/release strobes derived from the stable level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 270_000,
    parameter int CNT_W           = 25
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic i_btn_n,
    output logic o_stable,
    output logic o_press,
    output logic o_release
);

    // Counter value on which the last differing sample is seen.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_stable_d;

    // Bring the asynchronous raw button into sys_clk; resets to released.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Active-high view of the synchronised button.
    assign w_level = ~r_sync2;

    // Accept a new level only after it differs for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (w_level == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == DEB_LAST) begin
            r_stable <= w_level;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Delayed copy of the stable level for edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    // Strobes are pure functions of two registers, so they are glitch-free.
    assign o_stable  = r_stable;
    assign o_press   = r_stable & ~r_stable_d;
    assign o_release = ~r_stable & r_stable_d;

endmodule : btn_debounce

// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch button front end: debounces start/stop and lap, classifies
// start/stop presses as short (toggle run) or long (clear), and drives
// the lap-freeze controls for the counter/display stage.
module stopwatch_btn_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = stopwatch_pkg::DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = stopwatch_pkg::LONG_CYCLES,
    parameter int CNT_W           = 25
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic btn_startstop_n,
    input  logic btn_lap_n,
    output logic run,
    output logic clear_pulse,
    output logic lap_pulse,
    output logic lap_hold,
    output logic ss_pressed
);

    // Hold-counter value at which a press becomes a long press; the
    // counter stops here, so it can never wrap.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);

    logic [NUM_BTN-1:0] w_btn_n;
    logic [NUM_BTN-1:0] w_stable;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_release;
    logic               w_ss_press;
    logic               w_ss_release;
    logic               w_lap_press;
    logic               w_unused_lap;

    ss_state_t          r_state;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic               r_run;
    logic               r_clear;
    logic               r_lap_pulse;
    logic               r_lap_hold;

    assign w_btn_n[BTN_SS]  = btn_startstop_n;
    assign w_btn_n[BTN_LAP] = btn_lap_n;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .sys_clk   (sys_clk),
                .sys_rst   (sys_rst),
                .i_btn_n   (w_btn_n[gi]),
                .o_stable  (w_stable[gi]),
                .o_press   (w_press[gi]),
                .o_release (w_release[gi])
            );
        end
    endgenerate

    assign w_ss_press   = w_press[BTN_SS];
    assign w_ss_release = w_release[BTN_SS];
    assign w_lap_press  = w_press[BTN_LAP];

    // Only the lap press strobe matters; its level and release are not used.
    assign w_unused_lap = &{1'b0, w_stable[BTN_LAP], w_release[BTN_LAP]};

    // Start/stop classification FSM plus lap handling, all outputs registered.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_run       <= 1'b0;
            r_clear     <= 1'b0;
            r_lap_pulse <= 1'b0;
            r_lap_hold  <= 1'b0;
        end else begin
            r_clear     <= 1'b0;
            r_lap_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A start/stop press takes priority over a same-cycle lap press.
                    if (w_ss_press) begin
                        r_state    <= HELD;
                        r_hold_cnt <= '0;
                    end else if (w_lap_press) begin
                        if (r_run) begin
                            r_lap_hold  <= ~r_lap_hold;
                            r_lap_pulse <= 1'b1;
                        end else if (r_lap_hold) begin
                            r_lap_hold  <= 1'b0;
                            r_lap_pulse <= 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (w_ss_release) begin
                        // Short press: start or stop the watch.
                        r_run   <= ~r_run;
                        r_state <= IDLE;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        // Long press: stop, unfreeze and zero the counters once.
                        r_run      <= 1'b0;
                        r_lap_hold <= 1'b0;
                        r_clear    <= 1'b1;
                        r_state    <= LONG;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (w_ss_release) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign run         = r_run;
    assign clear_pulse = r_clear;
    assign lap_pulse   = r_lap_pulse;
    assign lap_hold    = r_lap_hold;
    assign ss_pressed  = w_stable[BTN_SS];

endmodule : stopwatch_btn_ctrl

// File: tb/tb_stopwatch_btn_ctrl.sv
// Self-checking bench for stopwatch_btn_ctrl: directed scenarios followed
// by random button activity, all compared every cycle with a reference model.
module tb_stopwatch_btn_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic btn_startstop_n = 1'b1;
    logic btn_lap_n = 1'b1;
    logic run, clear_pulse, lap_pulse, lap_hold, ss_pressed;

    always #5 sys_clk = ~sys_clk;

    stopwatch_btn_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .CNT_W           (25)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .btn_startstop_n (btn_startstop_n),
        .btn_lap_n       (btn_lap_n),
        .run             (run),
        .clear_pulse     (clear_pulse),
        .lap_pulse       (lap_pulse),
        .lap_hold        (lap_hold),
        .ss_pressed      (ss_pressed)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Observed pulse counts, cleared by scenarios that inspect them.
    int n_clear_obs = 0;
    int n_lap_obs   = 0;
    int n_ss_rise   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw samples still travelling through the synchroniser, per button.
    bit m_raw_hist[2][$];
    // Most recent synced samples since the last accepted level change.
    bit m_win[2][$];
    bit m_stable[2];
    bit m_stable_prev[2];
    bit m_run, m_lap_hold, m_clear, m_lap_pulse;
    bit m_holding;   // start/stop press in progress
    bit m_long;      // that press already counted as long
    int m_start;     // edge number at which the press was accepted

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            m_raw_hist[b] = {1'b1, 1'b1};
            m_win[b].delete();
            m_stable[b]      = 1'b0;
            m_stable_prev[b] = 1'b0;
        end
        m_run = 0; m_lap_hold = 0; m_clear = 0; m_lap_pulse = 0;
        m_holding = 0; m_long = 0; m_start = 0;
    endfunction

    function automatic void model_edge(input bit raw_ss_n, input bit raw_lap_n);
        bit p[2];
        bit r[2];
        bit raw[2];
        bit level;
        bit agree;
        raw[0] = raw_ss_n;
        raw[1] = raw_lap_n;
        for (int b = 0; b < 2; b++) begin
            p[b] = m_stable[b] && !m_stable_prev[b];
            r[b] = !m_stable[b] && m_stable_prev[b];
        end
        m_clear = 0;
        m_lap_pulse = 0;
        if (!m_holding) begin
            if (p[0]) begin
                m_holding = 1; m_long = 0; m_start = cyc;
            end else if (p[1]) begin
                if (m_run) begin
                    m_lap_hold = !m_lap_hold; m_lap_pulse = 1;
                end else if (m_lap_hold) begin
                    m_lap_hold = 0; m_lap_pulse = 1;
                end
            end
        end else if (!m_long) begin
            // Hold counter starts at 0 on acceptance and reads LONG-1
            // on the LONG-th edge after it.
            if (r[0]) begin
                m_run = !m_run; m_holding = 0;
            end else if (cyc - m_start == LONG) begin
                m_run = 0; m_lap_hold = 0; m_clear = 1; m_long = 1;
            end
        end else if (r[0]) begin
            m_holding = 0;
        end
        // Front end: level two edges old; accept after DEB consecutive
        // samples that disagree with the current stable level.
        for (int b = 0; b < 2; b++) begin
            m_stable_prev[b] = m_stable[b];
            level = !m_raw_hist[b][0];
            void'(m_raw_hist[b].pop_front());
            m_raw_hist[b].push_back(raw[b]);
            m_win[b].push_back(level);
            if (m_win[b].size() > DEB) void'(m_win[b].pop_front());
            agree = (m_win[b].size() == DEB);
            foreach (m_win[b][k]) if (m_win[b][k] == m_stable[b]) agree = 0;
            if (agree) begin
                m_stable[b] = !m_stable[b];
                m_win[b].delete();
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, "_run"},         int'(run),         int'(m_run));
        chk({tag, "_clear_pulse"}, int'(clear_pulse), int'(m_clear));
        chk({tag, "_lap_pulse"},   int'(lap_pulse),   int'(m_lap_pulse));
        chk({tag, "_lap_hold"},    int'(lap_hold),    int'(m_lap_hold));
        chk({tag, "_ss_pressed"},  int'(ss_pressed),  int'(m_stable[0]));
    endtask

    // One clock: advance model with the inputs present at the edge, then compare.
    task automatic tick();
        bit prev_ss;
        prev_ss = ss_pressed;
        @(posedge sys_clk);
        #1;
        cyc++;
        if (sys_rst) model_reset();
        else model_edge(btn_startstop_n, btn_lap_n);
        compare_all("cyc");
        if (clear_pulse) n_clear_obs++;
        if (lap_pulse) n_lap_obs++;
        if (ss_pressed && !prev_ss) n_ss_rise++;
    endtask

    task automatic drive(input bit ss_n, input bit lap_n, input int cycles);
        btn_startstop_n = ss_n;
        btn_lap_n = lap_n;
        repeat (cycles) tick();
    endtask

    // Asynchronous reset asserted between edges, held for some cycles.
    task automatic pulse_reset(input int cycles);
        sys_rst = 1'b1;
        #1;
        model_reset();
        compare_all("rst_async");
        repeat (cycles) tick();
        sys_rst = 1'b0;
    endtask

    task automatic clear_counts();
        n_clear_obs = 0; n_lap_obs = 0; n_ss_rise = 0;
    endtask

    initial begin
        int first;
        int len;
        model_reset();
        repeat (3) tick();
        chk("reset_run", int'(run), 0);
        chk("reset_ss_pressed", int'(ss_pressed), 0);
        sys_rst = 1'b0;
        drive(1, 1, 5);

        // Scenario 1: two short start/stop presses.
        clear_counts();
        drive(0, 1, 10);
        drive(1, 1, 20);
        chk("sc1_run_on", int'(run), 1);
        drive(0, 1, 10);
        drive(1, 1, 20);
        chk("sc1_run_off", int'(run), 0);
        chk("sc1_no_clear", n_clear_obs, 0);
        $display("sc1 short presses done, run=%0d", run);

        // Scenario 2: bounce shorter than the debounce window.
        clear_counts();
        for (int i = 0; i < 15; i++) drive(i % 2 == 1, 1, 2);
        drive(1, 1, 20);
        chk("sc2_no_ss_edge", n_ss_rise, 0);
        chk("sc2_run", int'(run), 0);
        $display("sc2 bounce rejected");

        // Scenario 4: lap presses while running, then while stopped.
        drive(0, 1, 10);
        drive(1, 1, 20);
        clear_counts();
        drive(1, 0, 10);
        drive(1, 1, 10);
        chk("sc4_lap_hold_on", int'(lap_hold), 1);
        drive(1, 0, 10);
        drive(1, 1, 10);
        chk("sc4_lap_hold_off", int'(lap_hold), 0);
        chk("sc4_two_pulses", n_lap_obs, 2);
        drive(0, 1, 10);
        drive(1, 1, 20);
        clear_counts();
        drive(1, 0, 10);
        drive(1, 1, 10);
        chk("sc4_stopped_no_pulse", n_lap_obs, 0);
        $display("sc4 lap handling done");

        // Scenario 3: long press while running with lap frozen.
        drive(0, 1, 10);
        drive(1, 1, 20);
        drive(1, 0, 10);
        drive(1, 1, 10);
        clear_counts();
        drive(0, 1, 40);
        chk("sc3_run_cleared", int'(run), 0);
        chk("sc3_lap_hold_cleared", int'(lap_hold), 0);
        drive(1, 1, 20);
        chk("sc3_one_clear", n_clear_obs, 1);
        chk("sc3_no_toggle", int'(run), 0);
        $display("sc3 long press done");

        // Scenario 5: both buttons pressed together while stopped.
        clear_counts();
        drive(0, 0, 10);
        drive(1, 1, 20);
        chk("sc5_no_lap_pulse", n_lap_obs, 0);
        chk("sc5_lap_hold", int'(lap_hold), 0);
        chk("sc5_ss_taken", int'(run), 1);
        $display("sc5 simultaneous press done");

        // Scenario 6: reset mid-HELD with the button kept down.
        drive(0, 1, 12);
        pulse_reset(3);
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (ss_pressed && first == 0) first = k;
        end
        chk("sc6_press_latency", first, 6);
        drive(1, 1, 20);
        $display("sc6 reset recovery done");

        // Random button activity, including bounce, long holds and resets.
        for (int seg = 0; seg < 90; seg++) begin
            len = ($urandom_range(0, 9) < 4) ? $urandom_range(1, 3) : $urandom_range(5, 45);
            if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 3));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len);
        end
        drive(1, 1, 40);
        $display("random phase done at cycle %0d", cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stopwatch_btn_ctrl
